bfly_sdf: RTL

- Parametrised radix-2 single-path delay-feedback (SDF) butterfly stage for the streaming FFT datapath.
- Owns its NUM_PAIR-deep delay line and emits sums and differences from the same streaming output.
- Supports input back-pressure and an explicit flush to drain stored differences.
- Tags each output with twiddle index and type so the downstream twiddle multiplier needs no separate counter.

---
 rtl/bfly_sdf_pkg.sv | 24 ++
 rtl/sdf_delay_mem.sv | 38 +++
 rtl/bfly_sdf.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bfly_sdf_pkg.sv
// Shared types and helpers for the radix-2 SDF butterfly stage.
//   sdf_state_t : FSM encoding (FILL, BFLY, FLUSH)
//   sext        : sign-extend the low w bits of a MAX_W-bit vector
//   rnd_half    : round-half-up divide by two, (v + 1) >>> 1
package bfly_sdf_pkg;

  typedef enum logic [1:0] {FILL, BFLY, FLUSH} sdf_state_t;

  localparam int MAX_W = 32;

  // Shift the w-bit field to the top, then arithmetic-shift it back down.
  function automatic logic signed [MAX_W-1:0] sext(input logic [MAX_W-1:0] x, input int w);
    logic [MAX_W-1:0] t;
    t = x << (MAX_W - w);
    return $signed(t) >>> (MAX_W - w);
  endfunction

  // Operand is already sign-extended to MAX_W, so the +1 cannot overflow
  // for any datapath width this block is used with.
  function automatic logic signed [MAX_W-1:0] rnd_half(input logic signed [MAX_W-1:0] v);
    return (v + 32'sd1) >>> 1;
  endfunction

endpackage

// File: rtl/sdf_delay_mem.sv
// Delay line for the SDF butterfly: DEPTH entries of (re, im), DW bits each.
// One combinational read port and one synchronous write port sharing addr.
// Contents are intentionally not reset.
// Ports:
//   clk          clock
//   we           write enable
//   addr         shared read/write address
//   wr_re/wr_im  write data
//   rd_re/rd_im  combinational read data at addr
module sdf_delay_mem
  import bfly_sdf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 13
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wr_re,
  input  logic [DW-1:0]            wr_im,
  output logic [DW-1:0]            rd_re,
  output logic [DW-1:0]            rd_im
);

  logic [DW-1:0] mem_re [DEPTH];
  logic [DW-1:0] mem_im [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_re[addr] <= wr_re;
      mem_im[addr] <= wr_im;
    end
  end

  assign rd_re = mem_re[addr];
  assign rd_im = mem_im[addr];

endmodule

// File: rtl/bfly_sdf.sv
// Radix-2 single-path delay-feedback butterfly stage.
// Streams sums and differences out of one registered port, tagging each with
// its pair index and sum/difference type for the downstream twiddle stage.
// Optional macro BFLY_SDF_ROUND_SCALE_EN: outputs are scaled by 1/2 with
// round-half-up; stored differences stay unscaled.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   din_valid/din_ready   input handshake (din_ready is combinational)
//   din_re/din_im         signed input sample, WIDTH bits
//   flush                 drain pending differences without new input
//   dout_valid            output strobe
//   dout_re/dout_im       signed output, WIDTH+1 bits
//   dout_is_diff          1 = difference, 0 = sum
//   dout_idx              pair index k (twiddle address)
//   block_done            pulse with difference k = NUM_PAIR-1
//
// state | meaning
// FILL  | store first half of a block; drain previous differences if pending
// BFLY  | emit sums, store differences in the delay line
// FLUSH | drain stored differences one per cycle, input stalled
module bfly_sdf
  import bfly_sdf_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int NUM_PAIR = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        din_valid,
  output logic                        din_ready,
  input  logic signed [WIDTH-1:0]     din_re,
  input  logic signed [WIDTH-1:0]     din_im,
  input  logic                        flush,
  output logic                        dout_valid,
  output logic signed [WIDTH:0]       dout_re,
  output logic signed [WIDTH:0]       dout_im,
  output logic                        dout_is_diff,
  output logic [$clog2(NUM_PAIR)-1:0] dout_idx,
  output logic                        block_done
);

  localparam int DW    = WIDTH + 1;
  localparam int CNT_W = $clog2(NUM_PAIR);

  sdf_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             pending;

  logic                 acc, flush_take, cnt_last;
  logic signed [DW-1:0] din_re_x, din_im_x;
  logic [DW-1:0]        rd_re_u, rd_im_u;
  logic signed [DW-1:0] rd_re, rd_im;
  logic signed [DW-1:0] wr_re, wr_im;
  logic signed [DW-1:0] res_re, res_im;
  logic signed [DW-1:0] out_re, out_im;

  assign flush_take = flush && (state == FILL) && (cnt == '0) && pending;
  assign din_ready  = (state != FLUSH) && !flush_take;
  assign acc        = din_valid && din_ready;
  assign cnt_last   = (cnt == CNT_W'(NUM_PAIR - 1));

  assign din_re_x = DW'(sext(MAX_W'(din_re), WIDTH));
  assign din_im_x = DW'(sext(MAX_W'(din_im), WIDTH));
  assign rd_re    = $signed(rd_re_u);
  assign rd_im    = $signed(rd_im_u);

  sdf_delay_mem #(
    .DEPTH (NUM_PAIR),
    .DW    (DW)
  ) u_mem (
    .clk   (clk),
    .we    (acc),
    .addr  (cnt),
    .wr_re (wr_re),
    .wr_im (wr_im),
    .rd_re (rd_re_u),
    .rd_im (rd_im_u)
  );

  // FILL stores the raw sample and emits the stored difference; BFLY emits
  // the sum and overwrites the entry with the difference.
  always_comb begin
    wr_re  = din_re_x;
    wr_im  = din_im_x;
    res_re = rd_re;
    res_im = rd_im;
    if (state == BFLY) begin
      wr_re  = rd_re - din_re_x;
      wr_im  = rd_im - din_im_x;
      res_re = rd_re + din_re_x;
      res_im = rd_im + din_im_x;
    end
  end

`ifdef BFLY_SDF_ROUND_SCALE_EN
  assign out_re = DW'(rnd_half(sext(MAX_W'(res_re), DW)));
  assign out_im = DW'(rnd_half(sext(MAX_W'(res_im), DW)));
`else
  assign out_re = res_re;
  assign out_im = res_im;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      cnt          <= '0;
      pending      <= 1'b0;
      dout_valid   <= 1'b0;
      dout_re      <= '0;
      dout_im      <= '0;
      dout_is_diff <= 1'b0;
      dout_idx     <= '0;
      block_done   <= 1'b0;
    end else begin
      dout_valid   <= 1'b0;
      dout_re      <= '0;
      dout_im      <= '0;
      dout_is_diff <= 1'b0;
      dout_idx     <= '0;
      block_done   <= 1'b0;
      case (state)
        FILL: begin
          if (flush_take) begin
            state <= FLUSH;
            cnt   <= '0;
          end else if (acc) begin
            if (pending) begin
              dout_valid   <= 1'b1;
              dout_re      <= out_re;
              dout_im      <= out_im;
              dout_is_diff <= 1'b1;
              dout_idx     <= cnt;
              block_done   <= cnt_last;
            end
            if (cnt_last) begin
              state   <= BFLY;
              pending <= 1'b0;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        BFLY: begin
          if (acc) begin
            dout_valid   <= 1'b1;
            dout_re      <= out_re;
            dout_im      <= out_im;
            dout_is_diff <= 1'b0;
            dout_idx     <= cnt;
            if (cnt_last) begin
              state   <= FILL;
              pending <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          dout_valid   <= 1'b1;
          dout_re      <= out_re;
          dout_im      <= out_im;
          dout_is_diff <= 1'b1;
          dout_idx     <= cnt;
          block_done   <= cnt_last;
          if (cnt_last) begin
            state   <= FILL;
            pending <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= FILL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
